cbfp_block_sched: RTL
=====================

Name: cbfp_block_sched

Overview:
- Frame-level scheduler that feeds the CBFP normalisation datapath in front of each FFT stage.
- Accepts 16-lane sample beats over a valid/ready handshake.
- Groups the beats into 64-sample blocks and issues each block as a contiguous 4-beat burst.
- Enforces the datapath's minimum block-to-block spacing and tracks blocks in flight.
- Signals frame completion or errors to the top-level FFT controller.

Parameters:
- BEATS_PER_BLOCK, 4, beats (of 16 lanes) per CBFP block.
- MIN_GAP, 32, minimum cycles between the first beats of consecutive issued blocks; must be >= BEATS_PER_BLOCK.
- NUM_BLOCKS, 8, blocks per frame (512-point frame).
- TIMEOUT, 255, maximum DRAIN cycles without a block retiring.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  frame start pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream beat ready.
- dp_in_valid  out  1  beat strobe to the CBFP datapath.
- dp_valid_out  in  1  datapath output-valid; one rising edge per retired block.
- blk_issue_idx  out  3  index of the block currently or last issued.
- blk_out_idx  out  3  index of the block currently leaving the datapath.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when all NUM_BLOCKS have retired.
- err_underrun  out  1  sticky; s_valid was low mid-burst.
- err_timeout  out  1  sticky; DRAIN watchdog expired.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE and all counters 0. Every output is 0, including both sticky errors and s_ready.
- States: IDLE, ISSUE, GAP, DRAIN.
- IDLE:
  - s_ready=0 and dp_in_valid=0.
  - start=1 -> ISSUE; clears issued/retired counters, blk_issue_idx, blk_out_idx and both error flags.
  - start in any other state is ignored.
- ISSUE:
  - Beat 0: s_ready=1 and the block waits for s_valid. The accept cycle (s_valid & s_ready) starts the burst, with dp_in_valid=1 that cycle.
  - Beats 1..BEATS_PER_BLOCK-1: s_ready=1 and dp_in_valid=1 unconditionally on each consecutive cycle.
  - If s_valid=0 on any of those beats, set err_underrun; the burst still completes with no stall.
  - gap_cnt loads MIN_GAP-1 on the beat-0 accept cycle and decrements every cycle until it reaches 0.
  - After the final beat: issued increments. If issued (new value) < NUM_BLOCKS -> GAP, otherwise -> DRAIN.
  - blk_issue_idx = issued count, updated on the beat-0 accept cycle.
- GAP:
  - s_ready=0 and dp_in_valid=0.
  - -> ISSUE on the cycle gap_cnt==0, so the next beat 0 can be accepted exactly MIN_GAP cycles after the previous one.
- Retire tracking, all states except IDLE:
  - Rising edge of dp_valid_out (registered previous value compared with current) -> retired increments and blk_out_idx = retired (old value).
  - Retires may coincide with issue beats; both counters update independently.
  - A retire when retired==issued is ignored.
- DRAIN:
  - The watchdog counter resets on each retire, otherwise increments.
  - retired==NUM_BLOCKS -> frame_done=1 for one cycle, then -> IDLE.
  - Watchdog reaching TIMEOUT -> err_timeout=1, then -> IDLE with no frame_done.
- abort:
  - Has priority over every transition. Next state is IDLE; s_ready and dp_in_valid go low the following cycle.
  - Counters and errors are held until the next start.
  - An abort mid-burst truncates the burst with no error.
- frame_done and a start in the same cycle: start is not seen (state is not yet IDLE). A start one cycle later is accepted.
- Latency:
  - start -> s_ready high: 1 cycle.
  - Last retire edge -> frame_done: 1 cycle.
- Widths: counters are 4 bits; indices wrap mod 8.

Test Plan:
- Nominal frame: start, s_valid held 1 -> dp_in_valid bursts of 4 begin at cycles 1, 33, 65, …, 225. Feed 8 dp_valid_out pulses -> frame_done 1 cycle after the 8th edge, busy falls, no errors.
- Late upstream: s_valid rises 10 cycles after start -> beat 0 at cycle 10. The next block's beat 0 is not earlier than cycle 42.
- Underrun: s_valid=0 on beat 2 of block 3 -> dp_in_valid still 4 cycles, err_underrun=1 and stays set through frame_done.
- Timeout: issue all 8 blocks, return only 6 retire edges -> err_timeout=1 255 cycles after the 6th edge, state IDLE, frame_done never pulses.
- Abort mid-burst: abort on beat 1 of block 0 -> s_ready=0 and dp_in_valid=0 next cycle, busy=0. A subsequent start clears errors and reissues from blk_issue_idx=0.
- Reset mid-frame: assert rst during GAP of block 4 -> all outputs 0 next cycle. Start after release -> a normal frame begins from block 0.

Source files
------------

// File: rtl/cbfp_block_sched.sv
// cbfp_block_sched
// ----------------
// Frame-level scheduler in front of the CBFP normalisation datapath of an
// FFT stage. Upstream 16-lane beats arrive over a valid/ready handshake and
// are grouped into blocks of BEATS_PER_BLOCK beats. Each block goes to the
// datapath as one contiguous burst. Consecutive block starts are kept at
// least MIN_GAP cycles apart. Blocks retiring from the datapath are counted
// so that frame completion, or a stalled datapath, can be reported.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   start          frame start pulse, honoured only while idle
//   abort          synchronous abort back to idle
//   s_valid        upstream beat valid
//   s_ready        upstream beat ready
//   dp_in_valid    beat strobe into the CBFP datapath
//   dp_valid_out   datapath output valid, one rising edge per retired block
//   blk_issue_idx  index of the block currently or last issued
//   blk_out_idx    index of the block currently leaving the datapath
//   busy           high whenever the scheduler is not idle
//   frame_done     one-cycle pulse once every block of the frame has retired
//   err_underrun   sticky, upstream had no beat ready in the middle of a burst
//   err_timeout    sticky, drain watchdog expired
module cbfp_block_sched #(
    parameter int BEATS_PER_BLOCK = 4,
    parameter int MIN_GAP         = 32,
    parameter int NUM_BLOCKS      = 8,
    parameter int TIMEOUT         = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       dp_in_valid,
    input  logic       dp_valid_out,
    output logic [2:0] blk_issue_idx,
    output logic [2:0] blk_out_idx,
    output logic       busy,
    output logic       frame_done,
    output logic       err_underrun,
    output logic       err_timeout
);

    localparam int BW = (BEATS_PER_BLOCK > 2) ? $clog2(BEATS_PER_BLOCK) : 1;
    localparam int GW = $clog2(MIN_GAP) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_BLOCK - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
    localparam logic [3:0]    NUM_BLK   = 4'(NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wdog;
    logic [3:0]    issued;
    logic [3:0]    retired;
    logic          dvo_q;

    logic          accept;
    logic          in_burst;
    logic          last_beat;
    logic          retire;
    logic          wdog_expire;

    // Per-cycle events. beat_cnt == 0 in ISSUE means the block is still
    // waiting for its first beat; any other value is a committed burst beat.
    // A retire is a rising edge on dp_valid_out, and it only counts while a
    // block is actually outstanding.
    always_comb begin
        in_burst    = (state == ISSUE) && (beat_cnt != '0);
        accept      = (state == ISSUE) && (beat_cnt == '0) && s_valid;
        last_beat   = in_burst && (beat_cnt == LAST_BEAT);
        retire      = (state != IDLE) && dp_valid_out && !dvo_q && (retired != issued);
        wdog_expire = (state == DRAIN) && (retired != NUM_BLK) && !retire
                      && (wdog == WDOG_LAST);
    end

    // Next-state and output decode. The spacing counter is loaded with
    // MIN_GAP-1 on the first beat and reaches zero exactly MIN_GAP cycles
    // later, so the state must already be ISSUE on that cycle. For that
    // reason GAP is left (or skipped) one cycle early, when the counter
    // reads 1. Abort overrides every other transition.
    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        dp_in_valid = 1'b0;
        frame_done  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                s_ready     = 1'b1;
                dp_in_valid = in_burst | s_valid;
                if (last_beat) begin
                    if ((issued + 4'd1) >= NUM_BLK) begin
                        state_nxt = DRAIN;
                    end else if (gap_cnt > GW'(1)) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GW'(1)) begin
                    state_nxt = ISSUE;
                end
            end
            DRAIN: begin
                if (retired == NUM_BLK) begin
                    frame_done = !abort;
                    state_nxt  = IDLE;
                end else if (wdog_expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // State, counters and sticky flags. A frame start clears everything the
    // previous frame left behind. An abort freezes counters and flags where
    // they are, so a truncated burst never raises an underrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            wdog          <= '0;
            issued        <= '0;
            retired       <= '0;
            dvo_q         <= 1'b0;
            blk_issue_idx <= '0;
            blk_out_idx   <= '0;
            err_underrun  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            dvo_q <= dp_valid_out;
            if (state == IDLE) begin
                if (start && !abort) begin
                    beat_cnt      <= '0;
                    gap_cnt       <= '0;
                    wdog          <= '0;
                    issued        <= '0;
                    retired       <= '0;
                    blk_issue_idx <= '0;
                    blk_out_idx   <= '0;
                    err_underrun  <= 1'b0;
                    err_timeout   <= 1'b0;
                end
            end else if (!abort) begin
                if (accept) begin
                    beat_cnt      <= BW'(1);
                    gap_cnt       <= GAP_LOAD;
                    blk_issue_idx <= issued[2:0];
                end else begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                    if (in_burst) begin
                        if (!s_valid) begin
                            err_underrun <= 1'b1;
                        end
                        if (last_beat) begin
                            beat_cnt <= '0;
                            issued   <= issued + 4'd1;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                if (retire) begin
                    retired     <= retired + 4'd1;
                    blk_out_idx <= retired[2:0];
                end
                if (state == DRAIN) begin
                    if (retire) begin
                        wdog <= '0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                    if (wdog_expire) begin
                        err_timeout <= 1'b1;
                    end
                end else begin
                    wdog <= '0;
                end
            end
        end
    end

endmodule
